// File: rtl/pipelined_addsub_pkg.sv
// rtl/pipelined_addsub_pkg.sv - shared types and helpers for pipelined_addsub
package addsub_pkg;

  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;

  function automatic int chunk_w(input int n, input int stages);
    return n / stages;
  endfunction

  // Limits are built 64 bits wide; callers truncate to the operand width.
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/pipelined_addsub_chunk_adder.sv
// rtl/pipelined_addsub_chunk_adder.sv - combinational ripple adder for one pipeline chunk
module chunk_adder
  import addsub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic c;

  always_comb begin
    c        = cin;
    c_msb_in = cin;
    s        = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - N-bit add/sub split into STAGES registered carry chunks
// Defining ADDSUB_SAT_EN clamps the result to the signed limit on overflow.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  localparam int CHUNK = chunk_w(N, STAGES);

  if (N % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_addsub: N must be a multiple of STAGES");
  end

  logic              advance;
  logic              op_sub;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      res_q [STAGES];
  logic              overflow_q;

  logic [N-1:0]      x_w   [STAGES];
  logic [N-1:0]      y_w   [STAGES];
  logic [N-1:0]      r_w   [STAGES];
  logic [STAGES-1:0] cin_w;
  logic [STAGES-1:0] cout_w;
  logic              cmsb_w [STAGES];
  logic [CHUNK-1:0]  s_w   [STAGES];
  logic [N-1:0]      res_d [STAGES];
  logic              overflow_d;

  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance;
  assign op_sub   = (op_t'(sub) == OP_SUB);

  // Full operands ride along every stage; each stage only consumes its own chunk.
  always_comb begin
    x_w[0]   = a;
    y_w[0]   = b ^ {N{op_sub}};
    cin_w[0] = op_sub;
    r_w[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      x_w[k]   = a_q[k-1];
      y_w[k]   = b_q[k-1];
      cin_w[k] = carry_q[k-1];
      r_w[k]   = res_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    chunk_adder #(.W(CHUNK)) u_add (
      .x        (x_w[k][k*CHUNK +: CHUNK]),
      .y        (y_w[k][k*CHUNK +: CHUNK]),
      .cin      (cin_w[k]),
      .s        (s_w[k]),
      .cout     (cout_w[k]),
      .c_msb_in (cmsb_w[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res_d[k]                   = r_w[k];
      res_d[k][k*CHUNK +: CHUNK] = s_w[k];
    end
    overflow_d = cout_w[STAGES-1] ^ cmsb_w[STAGES-1];
`ifdef ADDSUB_SAT_EN
    if (overflow_d) begin
      res_d[STAGES-1] = x_w[STAGES-1][N-1] ? N'(sat_min(N)) : N'(sat_max(N));
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      carry_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= x_w[k];
        b_q[k]     <= y_w[k];
        res_q[k]   <= res_d[k];
        carry_q[k] <= cout_w[k];
      end
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign carry_out = carry_q[STAGES-1];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (8/2, 32/4, 8/1)
module tb_pipelined_addsub;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       in_valid0, in_ready0, sub0, out_valid0, out_ready0, carry0, ovf0;
  logic [7:0] a0, b0, sum0;
  logic        in_valid1, in_ready1, sub1, out_valid1, carry1, ovf1;
  logic [31:0] a1, b1, sum1;
  logic       in_valid2, in_ready2, sub2, out_valid2, carry2, ovf2;
  logic [7:0] a2, b2, sum2;
  logic       one = 1'b1;

  pipelined_addsub #(.N(8), .STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .sub(sub0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .carry_out(carry0), .overflow(ovf0));

  pipelined_addsub #(.N(32), .STAGES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(one),
    .sum(sum1), .carry_out(carry1), .overflow(ovf1));

  pipelined_addsub #(.N(8), .STAGES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(one),
    .sum(sum2), .carry_out(carry2), .overflow(ovf2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on signed/unsigned interpretations.
  function automatic void model(input logic [63:0] av, input logic [63:0] bv, input logic s,
                                input int n, output logic [63:0] sm, output logic co,
                                output logic ov);
    logic [63:0] mask, full;
    longint sa, sb, r, lim;
    mask = (64'd1 << n) - 64'd1;
    full = s ? (av & mask) + ((~bv) & mask) + 64'd1 : (av & mask) + (bv & mask);
    co   = full[n];
    sm   = full & mask;
    lim  = longint'(64'd1 << (n - 1));
    sa   = av[n-1] ? longint'(av & mask) - 2 * lim : longint'(av & mask);
    sb   = bv[n-1] ? longint'(bv & mask) - 2 * lim : longint'(bv & mask);
    r    = s ? sa - sb : sa + sb;
    ov   = (r >= lim) || (r < -lim);
    if (SAT && ov) sm = av[n-1] ? (64'd1 << (n - 1)) : (64'd1 << (n - 1)) - 64'd1;
  endfunction

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } res_t;
  res_t        sbq[$];
  res_t        mon_e;
  logic [63:0] mon_s;
  logic        mon_c, mon_o;
  bit          sb_en = 1'b0;
  int          n_out = 0;

  // Handshakes sampled mid-cycle describe the transfer at the next rising edge.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (out_valid0 && out_ready0) begin
        n_out++;
        if (sbq.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_unexpected: output 0x%0h with no pending op", sum0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_sum", {56'd0, sum0}, {56'd0, mon_e.s});
          chk("sb_flags", {62'd0, carry0, ovf0}, {62'd0, mon_e.c, mon_e.o});
        end
      end
      if (in_valid0 && in_ready0) begin
        model({56'd0, a0}, {56'd0, b0}, sub0, 8, mon_s, mon_c, mon_o);
        sbq.push_back('{mon_s[7:0], mon_c, mon_o});
      end
    end
  end

  bit rnd_rdy = 1'b0;
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 out_ready0 = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic ss);
    int   t;
    logic acc;
    in_valid0 = 1'b1; a0 = aa; b0 = bb; sub0 = ss; t = 0;
    forever begin
      @(negedge clk);
      acc = in_ready0;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        break;
      end
    end
    in_valid0 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;
  vec_t tbl[8];

  int          lat, lat1, lat2, n_out0;
  longint      t0;
  logic [63:0] es;
  logic        ec, eo;
  bit          stale0, stale1, stale2;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h3C, 8'h41, 1'b0, 8'h7D, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b1, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_sum", {56'd0, sum0}, 64'd0);
    chk("rst_carry", {63'd0, carry0}, 64'd0);
    chk("rst_overflow", {63'd0, ovf0}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("rst_out_valid_n32", {63'd0, out_valid1}, 64'd0);
    chk("rst_out_valid_s1", {63'd0, out_valid2}, 64'd0);
    rst_n = 1'b1;
    idle(1);
    sb_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].sub);
      lat = 1;
      forever begin
        @(negedge clk);
        if (out_valid0 || lat > 10) break;
        lat++;
      end
      chk("tbl_latency", 64'(lat), 64'd2);
      chk("tbl_sum", {56'd0, sum0}, {56'd0, tbl[i].es});
      chk("tbl_carry", {63'd0, carry0}, {63'd0, tbl[i].ec});
      chk("tbl_overflow", {63'd0, ovf0}, {63'd0, tbl[i].eo});
      idle(1);
    end

    t0 = $time;
    for (int i = 0; i < 16; i++) send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    chk("stream_cycles", 64'(($time - t0) / 10), 64'd16);
    idle(5);
    chk("stream_drained", 64'(sbq.size()), 64'd0);

    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    rnd_rdy = 1'b0;
    idle(1);
    out_ready0 = 1'b1;
    idle(6);
    chk("random_ready_drained", 64'(sbq.size()), 64'd0);

    n_out0 = n_out;
    out_ready0 = 1'b0;
    send(8'h70, 8'h70, 1'b0);
    send(8'hF0, 8'h20, 1'b1);
    model(64'h70, 64'h70, 1'b0, 8, es, ec, eo);
    in_valid0 = 1'b1; a0 = 8'h55; b0 = 8'h66; sub0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, in_ready0}, 64'd0);
      chk("stall_out_valid", {63'd0, out_valid0}, 64'd1);
      chk("stall_sum", {56'd0, sum0}, {56'd0, es[7:0]});
      chk("stall_flags", {62'd0, carry0, ovf0}, {62'd0, ec, eo});
      idle(1);
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", {63'd0, in_ready0}, 64'd1);
    idle(1);
    in_valid0 = 1'b0;
    idle(5);
    chk("stall_drained", 64'(sbq.size()), 64'd0);
    chk("stall_out_count", 64'(n_out - n_out0), 64'd3);

    for (int i = 0; i < 4; i++) begin
      a1 = $urandom; b1 = $urandom; sub1 = i[0];
      a2 = 8'($urandom); b2 = 8'($urandom); sub2 = ~i[0];
      in_valid1 = 1'b1; in_valid2 = 1'b1;
      idle(1);
      in_valid1 = 1'b0; in_valid2 = 1'b0;
      lat1 = 0; lat2 = 0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (out_valid1 && lat1 == 0) begin
          lat1 = c;
          model({32'd0, a1}, {32'd0, b1}, sub1, 32, es, ec, eo);
          chk("n32_sum", {32'd0, sum1}, {32'd0, es[31:0]});
          chk("n32_flags", {62'd0, carry1, ovf1}, {62'd0, ec, eo});
        end
        if (out_valid2 && lat2 == 0) begin
          lat2 = c;
          model({56'd0, a2}, {56'd0, b2}, sub2, 8, es, ec, eo);
          chk("s1_sum", {56'd0, sum2}, {56'd0, es[7:0]});
          chk("s1_flags", {62'd0, carry2, ovf2}, {62'd0, ec, eo});
        end
      end
      chk("n32_latency", 64'(lat1), 64'd4);
      chk("s1_latency", 64'(lat2), 64'd1);
      idle(1);
    end

    sb_en = 1'b0;
    sbq.delete();
    in_valid0 = 1'b1; a0 = 8'h11; b0 = 8'h22; sub0 = 1'b0;
    in_valid1 = 1'b1; a1 = 32'h1234_5678; b1 = 32'h0F0F_0F0F; sub1 = 1'b1;
    in_valid2 = 1'b1; a2 = 8'h44; b2 = 8'h33; sub2 = 1'b1;
    idle(1);
    a0 = 8'h99; a1 = 32'hDEAD_BEEF; a2 = 8'h01;
    idle(1);
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("midrst_sum", {56'd0, sum0}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready0}, 64'd1);
    chk("midrst_out_valid_n32", {63'd0, out_valid1}, 64'd0);
    chk("midrst_out_valid_s1", {63'd0, out_valid2}, 64'd0);
    idle(2);
    #3 rst_n = 1'b1;
    stale0 = 1'b0; stale1 = 1'b0; stale2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      stale0 |= out_valid0;
      stale1 |= out_valid1;
      stale2 |= out_valid2;
    end
    chk("postrst_stale", {63'd0, stale0}, 64'd0);
    chk("postrst_stale_n32", {63'd0, stale1}, 64'd0);
    chk("postrst_stale_s1", {63'd0, stale2}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised N-bit adder/subtractor, pipelined into STAGES carry-chain chunks, so wide operands close timing at full clock rate.
- Each stage resolves CHUNK = N/STAGES bits and registers the carry into the next stage.
- Valid/ready handshake on input and output; accepts one operation per cycle when not back-pressured.
- Sits between operand registers and datapath consumers; replaces purely combinational ripple adders on wide paths.

Parameters:
N, 8, operand/result width in bits
STAGES, 2, pipeline depth; N % STAGES == 0 required (elaboration error otherwise); STAGES=1 legal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op presented this cycle
in_ready  output  1  block accepts when in_valid && in_ready
a  input  N  operand A
b  input  N  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts when out_valid && out_ready
sum  output  N  result (wraps mod 2^N)
carry_out  output  1  carry out of MSB (subtract: 1 = no borrow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync deassert by design): all stage valid bits 0, out_valid=0, sum=0, carry_out=0, overflow=0, all carry/skew/deskew registers 0. in_ready=1 out of reset.
- Operation: B' = b ^ {N{sub}}; stage-0 carry-in = sub. Stage k adds bits [k*CHUNK +: CHUNK] of A and B' with carry from stage k-1's register.
- Skew: upper operand chunks travel through delay registers until their stage. Deskew: completed lower result chunks travel with the transaction so sum is presented aligned.
- Latency: exactly STAGES cycles from accept to out_valid (no back-pressure).
- Flags, computed in the final stage:
  - carry_out = carry out of bit N-1.
  - overflow = carry into bit N-1 XOR carry out of bit N-1.
- Flow control, global stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - On advance, every stage register and valid bit shifts one stage; stage-0 valid loads (in_valid && in_ready).
  - When !advance, all pipeline registers hold; outputs stable while out_valid && !out_ready.
- Bubbles are not collapsed; throughput is 1 op/cycle when out_ready is held high.
- Simultaneous accept and output handshake in one cycle is legal and lossless.
- sub is captured per transaction; mixed add/sub streams are legal back-to-back.
- Reset mid-operation: in-flight transactions are discarded; no partial result is emitted after reset deasserts.
- Input values while !in_valid are ignored (don't-care).

Optional Feature:
ADDSUB_SAT_EN
- Defined: on overflow, sum is clamped to the signed limit. If A (MSB) is 0, sum = 2^(N-1)-1; otherwise sum = -2^(N-1). overflow still asserts. carry_out is unchanged (raw).
- Not defined: sum wraps mod 2^N; no clamping logic is present.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} op_t.
  - Function chunk_w(n, stages) returning n/stages.
  - Saturation limit helper functions used under ADDSUB_SAT_EN.
- Sub-module chunk_adder:
  - Parameter W; inputs x[W], y[W], cin.
  - Outputs s[W], cout, c_msb_in (carry into bit W-1, for overflow).
  - Combinational ripple; instantiated once per stage via generate.

Test Plan:
N=8, STAGES=2 unless stated.
- Add 0x7F+0x01, out_ready=1 -> 2 cycles later sum=0x80, carry_out=0, overflow=1; with ADDSUB_SAT_EN, sum=0x7F.
- Add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0; sub 0x05-0x07 -> sum=0xFE, carry_out=0, overflow=0.
- Sub 0x80-0x01 -> sum=0x7F, overflow=1, carry_out=1; with ADDSUB_SAT_EN, sum=0x80.
- Back-to-back stream of 16 random add/sub ops, out_ready=1 -> one result per cycle, in order, all matching a reference model.
- out_ready=0 for 5 cycles with pipeline full:
  - in_ready=0 and sum/flags held stable.
  - On release, results drain in order with no loss or duplication.
- Assert rst_n mid-stream with 2 ops in flight -> out_valid=0 immediately; after deassert, no stale result appears. Repeat with N=32, STAGES=4 and N=8, STAGES=1 for latency 4 and latency 1.
